// File: rtl/rob_unit_pkg.sv
// Shared reorder-buffer constants, instruction-class encodings and entry layout.
package rob_unit_pkg;

    localparam int ROB_BIT  = 5;
    localparam int ROB_SIZE = 1 << ROB_BIT;

    typedef logic [ROB_BIT-1:0] rob_tag_t;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_EXIT   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic      busy;
        logic      ready;
        rob_type_e kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pc;
        logic      pred_taken;
        logic      taken;
    } rob_entry_t;

endpackage

// File: rtl/rob_unit_if.sv
// Issue, writeback, operand-query and retire signals between the core and the ROB.
interface rob_unit_if
    import rob_unit_pkg::*;
();

    logic        issue_valid;
    rob_type_e   issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_pred_taken;
    rob_tag_t    issue_rob_entry;
    logic [4:0]  issue_reg_id;
    logic        rob_full;

    logic        cdb_valid;
    rob_tag_t    cdb_rob_entry;
    logic [31:0] cdb_value;
    logic        cdb_taken;

    rob_tag_t    query1_entry;
    logic        query1_ready;
    logic [31:0] query1_value;
    rob_tag_t    query2_entry;
    logic        query2_ready;
    logic [31:0] query2_value;

    logic [4:0]  commit_reg_id;
    logic [31:0] commit_reg_data;
    rob_tag_t    commit_rob_entry;
    logic        commit_store;
    logic        rob_clear_up;
    logic [31:0] redirect_pc;
    logic        exit_commit;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
        input  issue_rob_entry, issue_reg_id, rob_full,
        output cdb_valid, cdb_rob_entry, cdb_value, cdb_taken,
        output query1_entry, query2_entry,
        input  query1_ready, query1_value, query2_ready, query2_value,
        input  commit_reg_id, commit_reg_data, commit_rob_entry, commit_store,
        input  rob_clear_up, redirect_pc, exit_commit
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
        output issue_rob_entry, issue_reg_id, rob_full,
        input  cdb_valid, cdb_rob_entry, cdb_value, cdb_taken,
        input  query1_entry, query2_entry,
        output query1_ready, query1_value, query2_ready, query2_value,
        output commit_reg_id, commit_reg_data, commit_rob_entry, commit_store,
        output rob_clear_up, redirect_pc, exit_commit
    );

endinterface

// File: rtl/rob_query_port.sv
// Operand tag lookup: a live entry's stored result, overridden by a same-cycle CDB write.
module rob_query_port
    import rob_unit_pkg::*;
(
    input  rob_tag_t            query_entry,
    input  logic [ROB_SIZE-1:0] busy_vec,
    input  logic [ROB_SIZE-1:0] ready_vec,
    input  logic [31:0]         value_arr [ROB_SIZE],
    input  logic                cdb_valid,
    input  rob_tag_t            cdb_rob_entry,
    input  logic [31:0]         cdb_value,
    output logic                query_ready,
    output logic [31:0]         query_value
);

    // CDB bypass wins over stored state so a dependant can capture the result this cycle.
    always_comb begin
        query_ready = busy_vec[query_entry] && ready_vec[query_entry];
        query_value = value_arr[query_entry];
        if (cdb_valid && (cdb_rob_entry == query_entry) && busy_vec[query_entry]) begin
            query_ready = 1'b1;
            query_value = cdb_value;
        end
    end

endmodule

// File: rtl/rob_unit.sv
// Reorder buffer: in-order allocation, out-of-order writeback, single in-order retire per cycle.
module rob_unit
    import rob_unit_pkg::*;
(
    input logic       clk_in,
    input logic       rst_in,
    input logic       rdy_in,
    rob_unit_if.slave bus
);

    rob_entry_t          entries [ROB_SIZE];
    rob_tag_t            head;
    rob_tag_t            tail;
    logic [ROB_BIT:0]    count;
    logic [ROB_BIT:0]    count_next;
    rob_entry_t          head_entry;
    logic                commit_fire;
    logic                flush_fire;
    logic                issue_accept;
    logic [ROB_SIZE-1:0] busy_vec;
    logic [ROB_SIZE-1:0] ready_vec;
    logic [31:0]         value_arr [ROB_SIZE];

    logic [4:0]          commit_reg_id_q;
    logic [31:0]         commit_reg_data_q;
    rob_tag_t            commit_rob_entry_q;
    logic                commit_store_q;
    logic                clear_q;
    logic [31:0]         redirect_q;
    logic                exit_q;

    assign head_entry   = entries[head];
    assign commit_fire  = rdy_in && !exit_q && head_entry.busy && head_entry.ready;
    assign flush_fire   = commit_fire && (head_entry.kind == ROB_BRANCH)
                          && (head_entry.taken != head_entry.pred_taken);
    assign issue_accept = rdy_in && bus.issue_valid && !bus.rob_full && !flush_fire;
    assign count_next   = count + (ROB_BIT+1)'(issue_accept) - (ROB_BIT+1)'(commit_fire);

    assign bus.rob_full        = (count == (ROB_BIT+1)'(ROB_SIZE));
    assign bus.issue_rob_entry = tail;
    assign bus.issue_reg_id    = (issue_accept && bus.issue_type == ROB_REG) ? bus.issue_rd : 5'd0;

    assign bus.commit_reg_id    = commit_reg_id_q;
    assign bus.commit_reg_data  = commit_reg_data_q;
    assign bus.commit_rob_entry = commit_rob_entry_q;
    assign bus.commit_store     = commit_store_q;
    assign bus.rob_clear_up     = clear_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.exit_commit      = exit_q;

    // Flatten per-entry status into vectors for the two lookup ports.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].ready;
            value_arr[i] = entries[i].value;
        end
    end

    rob_query_port u_query1 (
        .query_entry   (bus.query1_entry),
        .busy_vec      (busy_vec),
        .ready_vec     (ready_vec),
        .value_arr     (value_arr),
        .cdb_valid     (bus.cdb_valid),
        .cdb_rob_entry (bus.cdb_rob_entry),
        .cdb_value     (bus.cdb_value),
        .query_ready   (bus.query1_ready),
        .query_value   (bus.query1_value)
    );

    rob_query_port u_query2 (
        .query_entry   (bus.query2_entry),
        .busy_vec      (busy_vec),
        .ready_vec     (ready_vec),
        .value_arr     (value_arr),
        .cdb_valid     (bus.cdb_valid),
        .cdb_rob_entry (bus.cdb_rob_entry),
        .cdb_value     (bus.cdb_value),
        .query_ready   (bus.query2_ready),
        .query_value   (bus.query2_value)
    );

    // Writeback, allocate, retire and flush; a mispredict flush overrides everything else.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            commit_reg_id_q    <= '0;
            commit_reg_data_q  <= '0;
            commit_rob_entry_q <= '0;
            commit_store_q     <= 1'b0;
            clear_q            <= 1'b0;
            redirect_q         <= '0;
            exit_q             <= 1'b0;
        end else begin
            commit_reg_id_q    <= '0;
            commit_reg_data_q  <= '0;
            commit_rob_entry_q <= '0;
            commit_store_q     <= 1'b0;
            clear_q            <= 1'b0;
            redirect_q         <= '0;
            if (rdy_in) begin
                if (bus.cdb_valid && entries[bus.cdb_rob_entry].busy) begin
                    entries[bus.cdb_rob_entry].ready <= 1'b1;
                    entries[bus.cdb_rob_entry].value <= bus.cdb_value;
                    entries[bus.cdb_rob_entry].taken <= bus.cdb_taken;
                end
                if (issue_accept) begin
                    entries[tail] <= '{busy:       1'b1,
                                       ready:      (bus.issue_type == ROB_STORE) ||
                                                   (bus.issue_type == ROB_EXIT),
                                       kind:       bus.issue_type,
                                       rd:         bus.issue_rd,
                                       value:      32'd0,
                                       pc:         bus.issue_pc,
                                       pred_taken: bus.issue_pred_taken,
                                       taken:      1'b0};
                    tail <= tail + rob_tag_t'(1);
                end
                if (commit_fire) begin
                    entries[head].busy  <= 1'b0;
                    entries[head].ready <= 1'b0;
                    head                <= head + rob_tag_t'(1);
                    commit_rob_entry_q  <= head;
                    case (head_entry.kind)
                        ROB_REG: begin
                            commit_reg_id_q   <= head_entry.rd;
                            commit_reg_data_q <= head_entry.value;
                        end
                        ROB_STORE:  commit_store_q <= 1'b1;
                        ROB_BRANCH: begin
                            if (flush_fire) begin
                                clear_q    <= 1'b1;
                                redirect_q <= head_entry.value;
                            end
                        end
                        ROB_EXIT:   exit_q <= 1'b1;
                    endcase
                end
                count <= count_next;
                if (flush_fire) begin
                    for (int i = 0; i < ROB_SIZE; i++) begin
                        entries[i].busy  <= 1'b0;
                        entries[i].ready <= 1'b0;
                    end
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_unit.sv
// Bench for rob_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_rob_unit;
    import rob_unit_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    rob_unit_if bus ();

    rob_unit dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: in-flight instructions in program order, oldest at index 0.
    typedef struct {
        int          tag;
        rob_type_e   kind;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] value;
        bit          pred;
        bit          taken;
    } model_entry_t;

    model_entry_t mq [$];
    int           mtail;
    bit           mexit;

    logic [4:0]  e_reg_id;
    logic [31:0] e_reg_data;
    logic [4:0]  e_entry;
    logic        e_store;
    logic        e_clear;
    logic [31:0] e_redirect;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int findTag(input int t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic bit commitNow();
        return rdy_in && !mexit && (mq.size() > 0) && mq[0].ready;
    endfunction

    function automatic bit flushNow();
        return commitNow() && (mq[0].kind == ROB_BRANCH) && (mq[0].taken != mq[0].pred);
    endfunction

    task automatic checkQuery(input string tag, input rob_tag_t q, input logic rdy_o, input logic [31:0] val_o);
        int          idx;
        logic        er;
        logic [31:0] ev;
        idx = findTag(int'(q));
        er  = 1'b0;
        ev  = 32'd0;
        if (idx >= 0) begin
            if (bus.cdb_valid && bus.cdb_rob_entry == q) begin
                er = 1'b1;
                ev = bus.cdb_value;
            end else if (mq[idx].ready) begin
                er = 1'b1;
                ev = mq[idx].value;
            end
        end
        checkOutput({tag, "_ready"}, 32'(rdy_o), 32'(er));
        if (er) checkOutput({tag, "_value"}, val_o, ev);
    endtask

    task automatic checkComb();
        logic [4:0] exp_id;
        exp_id = 5'd0;
        if (bus.issue_valid && rdy_in && mq.size() < ROB_SIZE && !flushNow() && bus.issue_type == ROB_REG)
            exp_id = bus.issue_rd;
        checkOutput("issue_rob_entry", 32'(bus.issue_rob_entry), 32'(mtail));
        checkOutput("rob_full", 32'(bus.rob_full), 32'(mq.size() == ROB_SIZE));
        checkOutput("issue_reg_id", 32'(bus.issue_reg_id), 32'(exp_id));
        checkQuery("query1", bus.query1_entry, bus.query1_ready, bus.query1_value);
        checkQuery("query2", bus.query2_entry, bus.query2_ready, bus.query2_value);
    endtask

    task automatic modelEdge();
        bit           do_commit;
        bit           do_flush;
        bit           accept;
        int           idx;
        model_entry_t ne;
        e_reg_id   = '0;
        e_reg_data = '0;
        e_entry    = '0;
        e_store    = 1'b0;
        e_clear    = 1'b0;
        e_redirect = '0;
        if (rst_in) begin
            mq.delete();
            mtail = 0;
            mexit = 1'b0;
        end else if (rdy_in) begin
            do_commit = commitNow();
            do_flush  = flushNow();
            accept    = bus.issue_valid && (mq.size() < ROB_SIZE) && !do_flush;
            if (do_commit) begin
                e_entry = 5'(mq[0].tag);
                case (mq[0].kind)
                    ROB_REG: begin
                        e_reg_id   = mq[0].rd;
                        e_reg_data = mq[0].value;
                    end
                    ROB_STORE: e_store = 1'b1;
                    ROB_BRANCH: begin
                        if (do_flush) begin
                            e_clear    = 1'b1;
                            e_redirect = mq[0].value;
                        end
                    end
                    ROB_EXIT: mexit = 1'b1;
                endcase
            end
            if (bus.cdb_valid) begin
                idx = findTag(int'(bus.cdb_rob_entry));
                if (idx >= 0) begin
                    mq[idx].ready = 1'b1;
                    mq[idx].value = bus.cdb_value;
                    mq[idx].taken = bus.cdb_taken;
                end
            end
            if (do_flush) begin
                mq.delete();
                mtail = 0;
            end else if (do_commit) begin
                void'(mq.pop_front());
            end
            if (accept) begin
                ne.tag   = mtail;
                ne.kind  = bus.issue_type;
                ne.rd    = bus.issue_rd;
                ne.ready = (bus.issue_type == ROB_STORE) || (bus.issue_type == ROB_EXIT);
                ne.value = 32'd0;
                ne.pred  = bus.issue_pred_taken;
                ne.taken = 1'b0;
                mq.push_back(ne);
                mtail = (mtail + 1) % ROB_SIZE;
            end
        end
    endtask

    task automatic checkRegs();
        checkOutput("commit_reg_id", 32'(bus.commit_reg_id), 32'(e_reg_id));
        checkOutput("commit_reg_data", bus.commit_reg_data, e_reg_data);
        checkOutput("commit_rob_entry", 32'(bus.commit_rob_entry), 32'(e_entry));
        checkOutput("commit_store", 32'(bus.commit_store), 32'(e_store));
        checkOutput("rob_clear_up", 32'(bus.rob_clear_up), 32'(e_clear));
        checkOutput("redirect_pc", bus.redirect_pc, e_redirect);
        checkOutput("exit_commit", 32'(bus.exit_commit), 32'(mexit));
    endtask

    task automatic applyStimulus(input bit iv, input rob_type_e kind, input logic [4:0] rd,
                                 input logic [31:0] pc, input bit pred, input bit cv,
                                 input rob_tag_t ce, input logic [31:0] cval, input bit ctaken);
        bus.issue_valid      = iv;
        bus.issue_type       = kind;
        bus.issue_rd         = rd;
        bus.issue_pc         = pc;
        bus.issue_pred_taken = pred;
        bus.cdb_valid        = cv;
        bus.cdb_rob_entry    = ce;
        bus.cdb_value        = cval;
        bus.cdb_taken        = ctaken;
        #1;
    endtask

    task automatic runCycle();
        if (!rst_in) checkComb();
        modelEdge();
        @(posedge clk_in);
        #1;
        checkRegs();
    endtask

    task automatic idle();
        applyStimulus(1'b0, ROB_REG, 5'd0, 32'd0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        runCycle();
    endtask

    task automatic issueOne(input rob_type_e kind, input logic [4:0] rd, input bit pred);
        applyStimulus(1'b1, kind, rd, $urandom, pred, 1'b0, '0, 32'd0, 1'b0);
        runCycle();
    endtask

    task automatic writeback(input rob_tag_t t, input logic [31:0] val, input bit taken);
        applyStimulus(1'b0, ROB_REG, 5'd0, 32'd0, 1'b0, 1'b1, t, val, taken);
        runCycle();
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        idle();
        idle();
        rst_in = 1'b0;
    endtask

    int        cand [$];
    int        cdb_pct;
    rob_type_e rk;
    rob_tag_t  rtag;

    initial begin
        $display("[TB] rob_unit bench starting");
        rdy_in            = 1'b1;
        rst_in            = 1'b1;
        bus.query1_entry  = '0;
        bus.query2_entry  = '0;
        mq.delete();
        mtail = 0;
        mexit = 1'b0;

        // Reset, then a single REG through writeback and commit.
        doReset();
        checkOutput("rst_issue_tag", 32'(bus.issue_rob_entry), 32'd0);
        checkOutput("rst_full", 32'(bus.rob_full), 32'd0);
        applyStimulus(1'b1, ROB_REG, 5'd5, 32'h0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("t1_issue_tag", 32'(bus.issue_rob_entry), 32'd0);
        checkOutput("t1_issue_reg", 32'(bus.issue_reg_id), 32'd5);
        runCycle();
        writeback(5'd0, 32'h1234, 1'b0);
        idle();
        checkOutput("t1_commit_id", 32'(bus.commit_reg_id), 32'd5);
        checkOutput("t1_commit_data", bus.commit_reg_data, 32'h1234);
        checkOutput("t1_commit_entry", 32'(bus.commit_rob_entry), 32'd0);

        // Fill to capacity, reject an issue, drain one, wrap the tail.
        doReset();
        for (int i = 0; i < ROB_SIZE; i++) issueOne(ROB_REG, 5'((i % 31) + 1), 1'b0);
        applyStimulus(1'b1, ROB_REG, 5'd7, 32'h40, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("t2_full", 32'(bus.rob_full), 32'd1);
        checkOutput("t2_reject_reg", 32'(bus.issue_reg_id), 32'd0);
        runCycle();
        writeback(5'd0, 32'hAA, 1'b0);
        idle();
        checkOutput("t2_commit_id", 32'(bus.commit_reg_id), 32'd1);
        checkOutput("t2_not_full", 32'(bus.rob_full), 32'd0);
        applyStimulus(1'b1, ROB_REG, 5'd9, 32'h44, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("t2_wrap_tag", 32'(bus.issue_rob_entry), 32'd0);
        runCycle();

        // Mispredicted branch with three younger, already-complete entries.
        doReset();
        issueOne(ROB_BRANCH, 5'd0, 1'b0);
        issueOne(ROB_REG, 5'd1, 1'b0);
        issueOne(ROB_REG, 5'd2, 1'b0);
        issueOne(ROB_REG, 5'd3, 1'b0);
        writeback(5'd1, 32'h11, 1'b0);
        writeback(5'd2, 32'h22, 1'b0);
        writeback(5'd3, 32'h33, 1'b0);
        writeback(5'd0, 32'h100, 1'b1);
        idle();
        checkOutput("t3_clear", 32'(bus.rob_clear_up), 32'd1);
        checkOutput("t3_redirect", bus.redirect_pc, 32'h100);
        idle();
        checkOutput("t3_clear_drop", 32'(bus.rob_clear_up), 32'd0);
        checkOutput("t3_no_young_commit", 32'(bus.commit_reg_id), 32'd0);
        applyStimulus(1'b1, ROB_REG, 5'd4, 32'h200, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("t3_tag_restart", 32'(bus.issue_rob_entry), 32'd0);
        runCycle();
        idle();
        checkOutput("t3_still_quiet", 32'(bus.commit_reg_id), 32'd0);

        // Same-cycle CDB bypass on a query port.
        doReset();
        issueOne(ROB_REG, 5'd1, 1'b0);
        issueOne(ROB_REG, 5'd2, 1'b0);
        issueOne(ROB_REG, 5'd3, 1'b0);
        bus.query1_entry = 5'd2;
        bus.query2_entry = 5'd1;
        applyStimulus(1'b0, ROB_REG, 5'd0, 32'd0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("t4_not_ready", 32'(bus.query1_ready), 32'd0);
        runCycle();
        applyStimulus(1'b0, ROB_REG, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 32'h55, 1'b0);
        checkOutput("t4_bypass_ready", 32'(bus.query1_ready), 32'd1);
        checkOutput("t4_bypass_value", bus.query1_value, 32'h55);
        runCycle();

        // Stall with rdy_in low, then REG and STORE retire.
        doReset();
        issueOne(ROB_REG, 5'd3, 1'b0);
        issueOne(ROB_STORE, 5'd0, 1'b0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ROB_REG, 5'd4, 32'h80, 1'b0, 1'b1, 5'd0, 32'h77, 1'b0);
            checkOutput("t5_stall_tag", 32'(bus.issue_rob_entry), 32'd2);
            runCycle();
            checkOutput("t5_stall_commit", 32'(bus.commit_reg_id), 32'd0);
        end
        rdy_in = 1'b1;
        writeback(5'd0, 32'h77, 1'b0);
        idle();
        checkOutput("t5_reg_commit", 32'(bus.commit_reg_id), 32'd3);
        idle();
        checkOutput("t5_store_pulse", 32'(bus.commit_store), 32'd1);
        checkOutput("t5_store_reg_id", 32'(bus.commit_reg_id), 32'd0);
        idle();
        checkOutput("t5_store_drop", 32'(bus.commit_store), 32'd0);

        // Random traffic: a filling phase, then a draining phase.
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            cdb_pct = (cyc < 150) ? 15 : 60;
            rdy_in  = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0:       rk = ROB_BRANCH;
                1:       rk = ROB_STORE;
                default: rk = ROB_REG;
            endcase
            cand.delete();
            foreach (mq[i]) if (!mq[i].ready) cand.push_back(mq[i].tag);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                rtag = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                rtag = 5'($urandom_range(0, ROB_SIZE - 1));
            bus.query1_entry = 5'($urandom_range(0, ROB_SIZE - 1));
            bus.query2_entry = (mq.size() > 0) ? 5'(mq[$urandom_range(0, mq.size() - 1)].tag)
                                               : 5'($urandom_range(0, ROB_SIZE - 1));
            applyStimulus(($urandom_range(0, 9) < 7), rk, 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 99) < cdb_pct), rtag,
                          $urandom, 1'($urandom_range(0, 1)));
            runCycle();
        end
        rdy_in = 1'b1;

        // REG with rd=0, then EXIT blocks every later commit.
        doReset();
        issueOne(ROB_REG, 5'd0, 1'b0);
        issueOne(ROB_EXIT, 5'd0, 1'b0);
        issueOne(ROB_REG, 5'd9, 1'b0);
        writeback(5'd0, 32'd7, 1'b0);
        writeback(5'd2, 32'd9, 1'b0);
        checkOutput("t6_rd0_id", 32'(bus.commit_reg_id), 32'd0);
        checkOutput("t6_rd0_data", bus.commit_reg_data, 32'd7);
        idle();
        checkOutput("t6_exit", 32'(bus.exit_commit), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("t6_exit_held", 32'(bus.exit_commit), 32'd1);
            checkOutput("t6_no_commit", 32'(bus.commit_reg_id), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
